iob_ahb2iob: RTL and testbench

//  AHB-Lite subordinate to IOb-native manager bridge; sits directly downstream of iob_axis2ahb.

---
 rtl/iob_ahb2iob_pkg.sv | 27 ++
 rtl/iob_ahb2iob.sv | 122 ++++++++++++
 tb/tb_iob_ahb2iob.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ahb2iob_pkg.sv
// rtl/iob_ahb2iob_pkg.sv - shared AHB codes and bridge FSM state encodings
package iob_ahb2iob_pkg;

  // HTRANS codes
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  // HRESP codes
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Bridge FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_ERR1    = 3'd4;
  localparam logic [2:0] ST_ERR2    = 3'd5;

  // Largest legal HSIZE for a bus of the given width (log2 of bytes per beat)
  function automatic logic [2:0] max_hsize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/iob_ahb2iob.sv
// rtl/iob_ahb2iob.sv - AHB-Lite subordinate to IOb-native manager bridge
module iob_ahb2iob
  import iob_ahb2iob_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  input  logic [ADDR_WIDTH-1:0]   s_ahb_addr_i,
  input  logic [2:0]              s_ahb_burst_i,
  input  logic                    s_ahb_mastlock_i,
  input  logic [3:0]              s_ahb_prot_i,
  input  logic [2:0]              s_ahb_size_i,
  input  logic [1:0]              s_ahb_trans_i,
  input  logic [DATA_WIDTH-1:0]   s_ahb_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_ahb_wstrb_i,
  input  logic                    s_ahb_write_i,
  input  logic                    s_ahb_sel_i,
  output logic [DATA_WIDTH-1:0]   s_ahb_rdata_o,
  output logic                    s_ahb_readyout_o,
  output logic                    s_ahb_resp_o,
  output logic                    iob_valid_o,
  output logic [ADDR_WIDTH-1:0]   iob_addr_o,
  output logic [DATA_WIDTH-1:0]   iob_wdata_o,
  output logic [DATA_WIDTH/8-1:0] iob_wstrb_o,
  input  logic                    iob_ready_i,
  input  logic                    iob_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   iob_rdata_i,
  output logic                    iob_rready_o
);

  localparam logic [2:0] MAX_SIZE = max_hsize(DATA_WIDTH);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  readyout;
  logic                  accept;
  logic                  rd_done;

  // HREADYOUT: the data phase ends as soon as the IOb side finishes, same cycle
  always_comb begin
    readyout = 1'b1;
    case (state_q)
      ST_WR_REQ:  readyout = iob_ready_i;
      ST_RD_REQ:  readyout = 1'b0;
      ST_RD_DATA: readyout = iob_rvalid_i;
      ST_ERR1:    readyout = 1'b0;
      default:    readyout = 1'b1;
    endcase
  end

  assign accept  = s_ahb_sel_i & s_ahb_trans_i[1] & readyout;
  assign rd_done = (state_q == ST_RD_DATA) & iob_rvalid_i;

  // Next state: a completing data phase may start the next access directly
  always_comb begin
    state_d = state_q;
    if (readyout) begin
      if (accept) begin
        if (s_ahb_size_i > MAX_SIZE) begin
          state_d = ST_ERR1;
        end else if (s_ahb_write_i) begin
          state_d = ST_WR_REQ;
        end else begin
          state_d = ST_RD_REQ;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_RD_REQ: if (iob_ready_i) state_d = ST_RD_DATA;
        ST_ERR1:   state_d = ST_ERR2;
        default:   state_d = state_q;
      endcase
    end
  end

  // State, address-phase capture and read-data hold register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= s_ahb_addr_i;
        write_q <= s_ahb_write_i;
        size_q  <= s_ahb_size_i;
      end
      if (rd_done) begin
        rdata_q <= iob_rdata_i;
      end
    end
  end

  // Read data passes through on completion so HRDATA is valid with HREADYOUT
  assign s_ahb_rdata_o    = rd_done ? iob_rdata_i : rdata_q;
  assign s_ahb_readyout_o = readyout;
  assign s_ahb_resp_o     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign iob_valid_o  = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = s_ahb_wdata_i;
  assign iob_wstrb_o  = (state_q == ST_WR_REQ) ? s_ahb_wstrb_i : '0;
  assign iob_rready_o = (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

  // Burst, lock and protection are not meaningful to a single-beat IOb access
  logic unused_inputs;
  assign unused_inputs = ^{s_ahb_burst_i, s_ahb_mastlock_i, s_ahb_prot_i,
                           s_ahb_trans_i[0], write_q, size_q};

endmodule

// File: tb/tb_iob_ahb2iob.sv
// tb/tb_iob_ahb2iob.sv - randomized self-checking bench for iob_ahb2iob
module tb_iob_ahb2iob;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          cke = 1'b1;
  logic          arst = 1'b1;
  logic [AW-1:0] s_addr = '0;
  logic [2:0]    s_burst = '0;
  logic          s_mastlock = 1'b0;
  logic [3:0]    s_prot = '0;
  logic [2:0]    s_size = '0;
  logic [1:0]    s_trans = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic          s_write = 1'b0;
  logic          s_sel = 1'b0;
  logic [DW-1:0] s_rdata;
  logic          s_readyout;
  logic          s_resp;
  logic          iob_valid;
  logic [AW-1:0] iob_addr;
  logic [DW-1:0] iob_wdata;
  logic [SW-1:0] iob_wstrb;
  logic          iob_ready = 1'b0;
  logic          iob_rvalid = 1'b0;
  logic [DW-1:0] iob_rdata = '0;
  logic          iob_rready;

  iob_ahb2iob #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .s_ahb_addr_i(s_addr), .s_ahb_burst_i(s_burst), .s_ahb_mastlock_i(s_mastlock),
    .s_ahb_prot_i(s_prot), .s_ahb_size_i(s_size), .s_ahb_trans_i(s_trans),
    .s_ahb_wdata_i(s_wdata), .s_ahb_wstrb_i(s_wstrb), .s_ahb_write_i(s_write),
    .s_ahb_sel_i(s_sel), .s_ahb_rdata_o(s_rdata), .s_ahb_readyout_o(s_readyout),
    .s_ahb_resp_o(s_resp), .iob_valid_o(iob_valid), .iob_addr_o(iob_addr),
    .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready),
    .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata), .iob_rready_o(iob_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    trans;
    logic          sel;
  } txn_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } iob_t;

  txn_t txq[$];
  iob_t exp_iob[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] sub_mem [256];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // IOb subordinate model: memory with programmable request stall and read latency
  int   stall_cnt = 0;
  bit   rand_ready = 1'b0;
  int   rvalid_dly = 1;
  bit   rd_pend = 1'b0;
  int   rd_cnt = 0;
  logic [DW-1:0] rd_data = '0;
  int   iob_wr_cnt = 0;
  iob_t sub_h;

  always begin
    @(posedge clk);
    #1;
    iob_ready  = (stall_cnt > 0) ? 1'b0 : (rand_ready ? 1'($urandom % 2) : 1'b1);
    iob_rvalid = rd_pend && (rd_cnt == 0);
    iob_rdata  = iob_rvalid ? rd_data : $urandom;
    @(negedge clk);
    if (arst) begin
      rd_pend   = 1'b0;
      stall_cnt = 0;
    end else begin
      if (iob_rvalid && iob_rready) rd_pend = 1'b0;
      else if (rd_pend && rd_cnt > 0) rd_cnt--;
      if (iob_valid) begin
        if (exp_iob.size() == 0) begin
          chk("iob_spurious", 64'(iob_valid), 64'd0);
        end else begin
          sub_h = exp_iob[0];
          chk("iob_addr", 64'(iob_addr), 64'(sub_h.addr));
          chk("iob_wstrb", 64'(iob_wstrb), sub_h.write ? 64'(sub_h.wstrb) : 64'd0);
          if (sub_h.write) chk("iob_wdata", 64'(iob_wdata), 64'(sub_h.wdata));
          if (iob_ready) begin
            void'(exp_iob.pop_front());
            if (iob_wstrb != '0) begin
              sub_mem[iob_addr[9:2]] = merge(sub_mem[iob_addr[9:2]], iob_wdata, iob_wstrb);
              iob_wr_cnt++;
            end else begin
              rd_pend = 1'b1;
              rd_data = sub_mem[iob_addr[9:2]];
              rd_cnt  = (rvalid_dly > 0) ? rvalid_dly - 1 : int'($urandom_range(0, 2));
            end
          end else if (stall_cnt > 0) begin
            stall_cnt--;
          end
        end
      end
    end
  end

  // AHB manager: drives queued transfers with address/data pipelining
  bit   pending = 1'b0;
  txn_t pend;
  bit   pend_err = 1'b0;
  int   waits = 0;
  int   last_waits = 0;
  int   run_cycles = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic drive_idle();
    s_sel   = 1'b0;
    s_trans = 2'd0;
  endtask

  task automatic add(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                     input logic [DW-1:0] d, input logic [SW-1:0] st, input logic [1:0] tr,
                     input logic sl);
    txn_t t;
    t.addr = a; t.write = w; t.size = sz; t.wdata = d; t.wstrb = st; t.trans = tr; t.sel = sl;
    txq.push_back(t);
  endtask

  task automatic run_queue();
    int   budget;
    bit   rd_completing;
    txn_t t;
    budget = 50 + 20 * txq.size();
    run_cycles = 0;
    pending = 1'b0;
    while ((txq.size() > 0 || pending) && budget > 0) begin
      @(posedge clk);
      #2;
      if (txq.size() > 0) begin
        s_addr  = txq[0].addr;
        s_write = txq[0].write;
        s_size  = txq[0].size;
        s_trans = txq[0].trans;
        s_sel   = txq[0].sel;
      end else begin
        drive_idle();
      end
      if (pending && pend.write) begin
        s_wdata = pend.wdata;
        s_wstrb = pend.wstrb;
      end else begin
        s_wdata = $urandom;
        s_wstrb = 4'($urandom);
      end
      @(negedge clk);
      run_cycles++;
      budget--;
      rd_completing = pending && !pend.write && !pend_err;
      if (s_readyout) begin
        if (!rd_completing) chk("rdata_hold", 64'(s_rdata), 64'(last_rd));
        if (pending) begin
          chk("resp", 64'(s_resp), 64'(pend_err));
          if (pend_err) begin
            chk("err_waits", 64'(waits), 64'd1);
          end else if (pend.write) begin
            ref_mem[pend.addr[9:2]] = merge(ref_mem[pend.addr[9:2]], pend.wdata, pend.wstrb);
          end else begin
            chk("rdata", 64'(s_rdata), 64'(ref_mem[pend.addr[9:2]]));
            last_rd = ref_mem[pend.addr[9:2]];
          end
          last_waits = waits;
          pending = 1'b0;
        end
        if (txq.size() > 0) begin
          t = txq.pop_front();
          if (t.sel && t.trans[1]) begin
            pending  = 1'b1;
            pend     = t;
            pend_err = (t.size > 3'd2);
            waits    = 0;
            if (!pend_err) exp_iob.push_back(iob_t'{t.addr, t.write, t.wdata, t.wstrb});
          end
        end
      end else begin
        chk("rdata_hold_wait", 64'(s_rdata), 64'(last_rd));
        if (!pending) begin
          chk("idle_ready", 64'(s_readyout), 64'd1);
        end else begin
          waits++;
          if (pend_err) chk("err1_resp", 64'(s_resp), 64'd1);
        end
      end
    end
    if (budget == 0) begin
      chk("timeout", 64'd1, 64'd0);
      pending = 1'b0;
      txq.delete();
    end
  endtask

  int wc;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      sub_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_readyout", 64'(s_readyout), 64'd1);
    chk("rst_resp", 64'(s_resp), 64'd0);
    chk("rst_rdata", 64'(s_rdata), 64'd0);
    chk("rst_valid", 64'(iob_valid), 64'd0);
    chk("rst_rready", 64'(iob_rready), 64'd0);
    @(posedge clk);
    #2;
    arst = 1'b0;

    // Single write with an always-ready subordinate: no wait states
    rand_ready = 1'b0;
    rvalid_dly = 1;
    wc = iob_wr_cnt;
    add(10'h010, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 2'd2, 1'b1);
    run_queue();
    chk("t1_waits", 64'(last_waits), 64'd0);
    chk("t1_wr_count", 64'(iob_wr_cnt - wc), 64'd1);

    // Read back: one wait state with 1-cycle rvalid
    add(10'h010, 1'b0, 3'd2, 32'h0, 4'h0, 2'd2, 1'b1);
    run_queue();
    chk("t2_waits", 64'(last_waits), 64'd1);
    chk("t2_last_rd", 64'(last_rd), 64'hDEADBEEF);

    // 256 back-to-back writes at one beat per cycle
    wc = iob_wr_cnt;
    for (int i = 0; i < 256; i++)
      add(10'(4 * i), 1'b1, 3'd2, 32'(i), 4'hF, (i == 0) ? 2'd2 : 2'd3, 1'b1);
    run_queue();
    chk("t3_cycles", 64'(run_cycles), 64'd257);
    chk("t3_wr_count", 64'(iob_wr_cnt - wc), 64'd256);

    // IOb stalls a write for 5 cycles
    stall_cnt = 5;
    wc = iob_wr_cnt;
    add(10'h020, 1'b1, 3'd2, 32'h12345678, 4'hF, 2'd2, 1'b1);
    run_queue();
    chk("t4_waits", 64'(last_waits), 64'd5);
    chk("t4_wr_count", 64'(iob_wr_cnt - wc), 64'd1);

    // Oversized HSIZE gives a two-cycle ERROR, then a normal read recovers
    add(10'h030, 1'b0, 3'd3, 32'h0, 4'h0, 2'd2, 1'b1);
    add(10'h020, 1'b0, 3'd2, 32'h0, 4'h0, 2'd2, 1'b1);
    run_queue();
    chk("t5_last_rd", 64'(last_rd), 64'h12345678);

    // Randomized mix of reads, writes, idles, deselects and errors
    rand_ready = 1'b1;
    rvalid_dly = 0;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] tr;
      tr = 2'($urandom % 4);
      add(10'($urandom), 1'($urandom % 2), ($urandom % 10 == 0) ? 3'd3 : 3'($urandom % 3),
          $urandom, 4'($urandom_range(1, 15)), tr, ($urandom % 8) != 0);
    end
    run_queue();

    // Reset during RD_DATA aborts the read; next read completes normally
    rand_ready = 1'b0;
    rvalid_dly = 5;
    @(posedge clk);
    #2;
    s_addr = 10'h010; s_write = 1'b0; s_size = 3'd2; s_trans = 2'd2; s_sel = 1'b1;
    @(negedge clk);
    chk("t6_accept", 64'(s_readyout), 64'd1);
    exp_iob.push_back(iob_t'{10'h010, 1'b0, 32'h0, 4'h0});
    @(posedge clk);
    #2;
    drive_idle();
    @(negedge clk);
    chk("t6_rdreq_wait", 64'(s_readyout), 64'd0);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("t6_rready", 64'(iob_rready), 64'd1);
    chk("t6_rddata_wait", 64'(s_readyout), 64'd0);
    @(posedge clk);
    #2;
    arst = 1'b1;
    @(negedge clk);
    chk("t6_rst_readyout", 64'(s_readyout), 64'd1);
    chk("t6_rst_rready", 64'(iob_rready), 64'd0);
    chk("t6_rst_valid", 64'(iob_valid), 64'd0);
    chk("t6_rst_rdata", 64'(s_rdata), 64'd0);
    @(posedge clk);
    #2;
    arst = 1'b0;
    last_rd = '0;
    rvalid_dly = 1;
    exp_iob.delete();
    add(10'h000, 1'b0, 3'd2, 32'h0, 4'h0, 2'd2, 1'b1);
    run_queue();
    chk("t6_waits", 64'(last_waits), 64'd1);

    repeat (4) @(negedge clk);
    chk("exp_iob_empty", 64'(exp_iob.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
